i2c_fnd_master: RTL

Single-byte I2C write initiator that drives the FND display slave (7-bit address 7'b1110000) from the on-chip controller side. On a one-cycle request it issues START, the address byte with R/W=0, one data byte and STOP, sampling the slave's ACK bit after each byte. It sits between the CPU/APB register block and the board SCL/SDA pins, and is the counterpart of the FND slave receiver.

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_tick_gen.sv | 29 ++
 rtl/i2c_fnd_master.sv | 139 +++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the FND-display I2C write initiator.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ACK_A,
    DATA,
    ACK_D,
    STOP
  } i2c_m_state_e;

  localparam logic [6:0] FND_ADDR         = 7'b1110000;
  localparam logic       RW_WRITE         = 1'b0;
  localparam logic       RW_READ          = 1'b1;
  localparam int         QUARTERS_PER_BIT = 4;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick divider: one-clk tick every CLK_DIV clocks while enabled.
module i2c_tick_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/i2c_fnd_master.sv
// Single-byte I2C write initiator: START, address+W, one data byte, STOP.
module i2c_fnd_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV   = 250,
  parameter int CHECK_ACK = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_req,
  input  logic [6:0] slave_addr,
  input  logic [7:0] tx_data,
  output logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  localparam logic [1:0] LAST_Q = 2'(QUARTERS_PER_BIT - 1);

  i2c_m_state_e state, state_n;
  logic [1:0] phase, phase_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shreg, shreg_n;
  logic [7:0] dbyte, dbyte_n;
  logic       ack_err_n, done_n, accept, tick, sda_in, sda_low;
  logic [1:0] levels_n;

  // Bus levels {scl, sda_low} for a given state, quarter and current bit.
  function automatic logic [1:0] bus_levels(input i2c_m_state_e st,
                                            input logic [1:0] q,
                                            input logic bit_val);
    case (st)
      START:        return {1'b1, q[1]};
      ADDR, DATA:   return {q[1], ~bit_val};
      ACK_A, ACK_D: return {q[1], 1'b0};
      STOP:         return {(q != 2'd0), ~q[1]};
      default:      return {1'b1, 1'b0};
    endcase
  endfunction

  assign sda_in = sda;
  assign sda    = sda_low ? 1'b0 : 1'bz;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (busy),
    .clr   (accept),
    .tick  (tick)
  );

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    bit_n     = bit_cnt;
    shreg_n   = shreg;
    dbyte_n   = dbyte;
    ack_err_n = ack_err;
    done_n    = 1'b0;
    accept    = 1'b0;
    if (state == IDLE) begin
      if (start_req) begin
        accept    = 1'b1;
        state_n   = START;
        phase_n   = 2'd0;
        bit_n     = 3'd0;
        shreg_n   = {slave_addr, RW_WRITE};
        dbyte_n   = tx_data;
        ack_err_n = 1'b0;
      end
    end else if (tick) begin
      phase_n = phase + 1'b1;
      if ((state == ACK_A || state == ACK_D) && phase == 2'd2 && sda_in)
        ack_err_n = 1'b1;
      if (phase == LAST_Q) begin
        case (state)
          START: begin
            state_n = ADDR;
            bit_n   = 3'd0;
          end
          ADDR, DATA: begin
            shreg_n = {shreg[6:0], 1'b0};
            bit_n   = bit_cnt + 1'b1;
            if (bit_cnt == 3'd7)
              state_n = (state == ADDR) ? ACK_A : ACK_D;
          end
          ACK_A: begin
            if (ack_err_n && CHECK_ACK != 0) begin
              state_n = STOP;
            end else begin
              state_n = DATA;
              shreg_n = dbyte;
              bit_n   = 3'd0;
            end
          end
          ACK_D: state_n = STOP;
          STOP: begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // Pins are registered from next-state values so they move exactly on tick edges.
  assign levels_n = bus_levels(state_n, phase_n, shreg_n[7]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      phase   <= 2'd0;
      bit_cnt <= 3'd0;
      ack_err <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      scl     <= 1'b1;
      sda_low <= 1'b0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      bit_cnt <= bit_n;
      ack_err <= ack_err_n;
      busy    <= (state_n != IDLE);
      done    <= done_n;
      scl     <= levels_n[1];
      sda_low <= levels_n[0];
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_n;
    dbyte <= dbyte_n;
  end

endmodule
